// File: rtl/slc_carry_chain_sequencer_if.sv
// slc_carry_chain_sequencer_if: requester, response and logic-cell pin bundle for the carry-chain sequencer
interface slc_carry_chain_sequencer_if #(parameter int NSLICE = 4);
    localparam int W = 8 * NSLICE;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         req_sub;
    logic         req_ci;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_sum;
    logic         rsp_co;
    logic         rsp_ovf;
    logic [7:0]   slc_a;
    logic [7:0]   slc_b;
    logic         slc_ci;
    logic         slc_qen;
    logic [7:0]   slc_fz;
    logic         slc_co;
    modport slave (
        input  req_valid, req_a, req_b, req_sub, req_ci, rsp_ready, slc_fz, slc_co,
        output req_ready, rsp_valid, rsp_sum, rsp_co, rsp_ovf, slc_a, slc_b, slc_ci, slc_qen
    );
    modport master (
        output req_valid, req_a, req_b, req_sub, req_ci, rsp_ready, slc_fz, slc_co,
        input  req_ready, rsp_valid, rsp_sum, rsp_co, rsp_ovf, slc_a, slc_b, slc_ci, slc_qen
    );
endinterface

// File: rtl/slc_carry_chain_sequencer.sv
// slc_carry_chain_sequencer: NSLICE-pass add/subtract through one shared 8-bit ripple-carry logic cell
module slc_carry_chain_sequencer #(
    parameter int NSLICE = 4
) (
    input logic                        QCK,
    input logic                        QRT,
    slc_carry_chain_sequencer_if.slave bus
);
    localparam int W  = 8 * NSLICE;
    localparam int IW = $clog2(NSLICE) + 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d, co_q, co_d, ovf_q, ovf_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic          run, last;
    assign run  = state_q == RUN;
    assign last = idx_q == IW'(NSLICE - 1);
    always_ff @(posedge QCK) begin
        if (QRT) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
        end
    end
    // Operands shift down one slice per pass so the live slice is always bits [7:0];
    // the sum fills from the top, landing fully aligned after the last pass.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        co_d    = co_q;
        ovf_d   = ovf_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        if (state_q == IDLE && bus.req_valid) begin
            a_d     = bus.req_a;
            b_d     = bus.req_sub ? ~bus.req_b : bus.req_b;
            carry_d = bus.req_sub | bus.req_ci;
            idx_d   = '0;
            state_d = RUN;
        end
        if (run) begin
            a_d     = a_q >> 8;
            b_d     = b_q >> 8;
            sum_d   = W'({bus.slc_fz, sum_q} >> 8);
            carry_d = bus.slc_co;
            idx_d   = last ? '0 : idx_q + IW'(1);
            if (last) begin
                state_d = DONE;
                co_d    = bus.slc_co;
                ovf_d   = (a_q[7] == b_q[7]) && (bus.slc_fz[7] != a_q[7]);
            end
        end
        if (state_q == DONE && bus.rsp_ready) state_d = IDLE;
    end
    assign bus.req_ready = state_q == IDLE;
    assign bus.rsp_valid = state_q == DONE;
    assign bus.rsp_sum   = sum_q;
    assign bus.rsp_co    = co_q;
    assign bus.rsp_ovf   = ovf_q;
    assign bus.slc_a     = run ? a_q[7:0] : 8'h00;
    assign bus.slc_b     = run ? b_q[7:0] : 8'h00;
    assign bus.slc_ci    = run & carry_q;
    assign bus.slc_qen   = run;
endmodule

// File: tb/tb_slc_carry_chain_sequencer.sv
// tb_slc_carry_chain_sequencer: directed plus random add/subtract checked against a wide-arithmetic model
module tb_slc_carry_chain_sequencer;
    localparam int N = 4;
    logic QCK = 1'b0;
    logic QRT = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;

    slc_carry_chain_sequencer_if #(.NSLICE(N)) bus();
    slc_carry_chain_sequencer #(.NSLICE(N)) dut (.QCK(QCK), .QRT(QRT), .bus(bus));

    // 8-bit ripple-carry cell: FZ/CO = A + B + CI
    assign {bus.slc_co, bus.slc_fz} = {1'b0, bus.slc_a} + {1'b0, bus.slc_b} + {8'b0, bus.slc_ci};

    always #5 QCK = ~QCK;

    task automatic tick();
        @(posedge QCK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // {co, ovf, sum} from plain 32-bit arithmetic
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic sub, input logic ci);
        logic [32:0] f;
        logic        co, ovf;
        if (sub) begin
            f   = {1'b0, a} - {1'b0, b};
            co  = a >= b;
            ovf = (a[31] != b[31]) && (f[31] != a[31]);
        end else begin
            f   = {1'b0, a} + {1'b0, b} + {32'b0, ci};
            co  = f[32];
            ovf = (a[31] == b[31]) && (f[31] != a[31]);
        end
        return {co, ovf, f[31:0]};
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub, input logic ci, input int bp);
        logic [33:0] e;
        logic [7:0]  eb;
        int          cyc, qen;
        e  = model(a, b, sub, ci);
        eb = b[7:0];
        if (sub) eb = ~eb;
        bus.req_a = a;
        bus.req_b = b;
        bus.req_sub = sub;
        bus.req_ci = ci;
        bus.req_valid = 1'b1;
        bus.rsp_ready = 1'b0;
        chk("req_ready_idle", bus.req_ready, 1);
        tick();
        bus.req_valid = bp > 0;
        chk("slc_a_pass0", bus.slc_a, a[7:0]);
        chk("slc_b_pass0", bus.slc_b, eb);
        chk("slc_ci_pass0", bus.slc_ci, sub | ci);
        cyc = 1;
        qen = 0;
        while (!bus.rsp_valid && cyc < 20) begin
            qen += bus.slc_qen;
            tick();
            cyc++;
        end
        chk("latency", cyc, N + 1);
        chk("qen_cycles", qen, N);
        chk("rsp_sum", bus.rsp_sum, e[31:0]);
        chk("rsp_co", bus.rsp_co, e[33]);
        chk("rsp_ovf", bus.rsp_ovf, e[32]);
        for (int i = 0; i < bp; i++) begin
            tick();
            chk("bp_valid", bus.rsp_valid, 1);
            chk("bp_sum", bus.rsp_sum, e[31:0]);
            chk("bp_co_ovf", {bus.rsp_co, bus.rsp_ovf}, e[33:32]);
            chk("bp_req_ready", bus.req_ready, 0);
            chk("bp_qen", bus.slc_qen, 0);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("valid_drop", bus.rsp_valid, 0);
        chk("ready_back", bus.req_ready, 1);
        chk("sum_kept", bus.rsp_sum, e[31:0]);
    endtask

    initial begin
        logic [33:0] e1, e2;
        logic [31:0] s[2];
        logic        c[2];
        int          t[2];
        int          nresp, cyc;
        logic        seen;
        bus.req_valid = 1'b0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_sub = 1'b0;
        bus.req_ci = 1'b0;
        bus.rsp_ready = 1'b0;
        repeat (2) tick();
        chk("rst_valid", bus.rsp_valid, 0);
        chk("rst_sum", bus.rsp_sum, 0);
        chk("rst_co_ovf", {bus.rsp_co, bus.rsp_ovf}, 0);
        chk("rst_slc", {bus.slc_a, bus.slc_b, bus.slc_ci, bus.slc_qen}, 0);
        QRT = 1'b0;
        tick();
        chk("rst_req_ready", bus.req_ready, 1);

        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 0);
        run_op(32'h00000005, 32'h00000007, 1'b1, 1'b0, 0);
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 0);
        run_op(32'h80000000, 32'h00000001, 1'b1, 1'b0, 0);
        run_op(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b1, 3);
        run_op(32'hCAFEBABE, 32'h0BADF00D, 1'b1, 1'b1, 0);
        for (int k = 0; k < 16; k++)
            run_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        bus.req_valid = 1'b0;

        bus.req_a = 32'hA5A5A5A5;
        bus.req_b = 32'h5A5A5A5A;
        bus.req_sub = 1'b0;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        tick();
        chk("abort_qen_before", bus.slc_qen, 1);
        QRT = 1'b1;
        tick();
        chk("abort_qen", bus.slc_qen, 0);
        chk("abort_valid", bus.rsp_valid, 0);
        chk("abort_sum", bus.rsp_sum, 0);
        QRT = 1'b0;
        tick();
        chk("abort_req_ready", bus.req_ready, 1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            seen |= bus.rsp_valid;
            tick();
        end
        chk("abort_no_rsp", seen, 0);

        e1 = model(32'h01020304, 32'h10203040, 1'b0, 1'b1);
        e2 = model(32'h11111111, 32'h11111111, 1'b1, 1'b0);
        bus.req_a = 32'h01020304;
        bus.req_b = 32'h10203040;
        bus.req_sub = 1'b0;
        bus.req_ci = 1'b1;
        bus.req_valid = 1'b1;
        bus.rsp_ready = 1'b1;
        tick();
        bus.req_a = 32'h11111111;
        bus.req_b = 32'h11111111;
        bus.req_sub = 1'b1;
        bus.req_ci = 1'b0;
        nresp = 0;
        cyc = 1;
        t[0] = 0; t[1] = 0; s[0] = '0; s[1] = '0; c[0] = 1'b0; c[1] = 1'b0;
        while (cyc < 30 && nresp < 2) begin
            if (bus.rsp_valid) begin
                t[nresp] = cyc;
                s[nresp] = bus.rsp_sum;
                c[nresp] = bus.rsp_co;
                nresp++;
            end
            tick();
            cyc++;
        end
        chk("b2b_count", nresp, 2);
        chk("b2b_lat", t[0], N + 1);
        chk("b2b_spacing", t[1] - t[0], N + 2);
        chk("b2b_sum0", s[0], e1[31:0]);
        chk("b2b_sum1", s[1], e2[31:0]);
        chk("b2b_co1", c[1], e2[33]);
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        QRT = 1'b1;
        tick();
        QRT = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
